dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Load/store sequencer directly upstream of DMEM_TopLevel.
- Accepts one load or store request at a time from the core over a valid/ready handshake.
- Drives DMEM's address, read_write and data_in, and waits a fixed memory latency.
- For loads, captures dataOut and returns it over a valid/ready response channel.

Parameters:
- DATA_W, 16: data word width; must match DMEM data_in/dataOut.
- ADDR_W, 13: address width; bits [12:10] select the bank, bits [9:0] are the word offset.
- MEM_LAT, 2: cycles from address presentation to valid dataOut, or to write commit; legal range 1..15.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: core request present.
- req_ready, output, 1: controller can accept a request.
- req_we, input, 1: 1 = store, 0 = load.
- req_addr, input, ADDR_W: request address.
- req_wdata, input, DATA_W: store data.
- rsp_valid, output, 1: load data available.
- rsp_ready, input, 1: core accepts load data.
- rsp_rdata, output, DATA_W: load data.
- rsp_err, output, 1: error flag accompanying rsp_valid or store completion.
- busy, output, 1: high in any state other than IDLE.
- mem_address, output, ADDR_W: to DMEM address.
- mem_read_write, output, 1: to DMEM read_write; 1 = read, 0 = write.
- mem_data_in, output, DATA_W: to DMEM data_in.
- mem_data_out, input, DATA_W: from DMEM dataOut.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - req_ready = 1, rsp_valid = 0, rsp_err = 0, busy = 0.
  - rsp_rdata = 0, mem_address = 0, mem_read_write = 1, mem_data_in = 0.
  - Latency counter = 0.
- Reset asserted mid-operation aborts the operation. A store in WAIT may or may not have committed in DMEM; no retry is issued.
- States:
  - IDLE -> ACCESS on req_valid && req_ready.
  - ACCESS -> WAIT unconditionally; one cycle.
  - WAIT -> RESP when the counter reaches MEM_LAT-1 and the request is a load.
  - WAIT -> IDLE when the counter reaches MEM_LAT-1 and the request is a store.
  - RESP -> IDLE on rsp_ready.
- Accept:
  - In IDLE, req_ready = 1.
  - The handshake registers req_addr into mem_address, req_wdata into mem_data_in, and drives mem_read_write = ~req_we.
  - req_ready = 0 in all other states. No request queue; back-to-back accepts are never possible.
- ACCESS/WAIT:
  - mem_address, mem_data_in and mem_read_write are held stable.
  - The counter clears on entry to WAIT and increments each cycle.
  - Total load latency from handshake to rsp_valid = MEM_LAT + 2 cycles.
- Store completion:
  - On exit from WAIT, mem_read_write returns to 1 the same edge, so write is asserted for exactly MEM_LAT+1 cycles.
  - No response beat is produced for a store.
- RESP:
  - rsp_rdata is captured from mem_data_out on the WAIT->RESP edge.
  - rsp_valid = 1 and rsp_rdata are held stable until rsp_ready.
  - rsp_valid deasserts on the edge after the handshake; req_ready rises on that same edge.
- With rsp_valid=1 and rsp_ready=0 indefinitely: the block stalls in RESP and no new request is accepted.
- In IDLE, mem_read_write = 1 always, so DMEM is never written spuriously.
- Address wrap: none. Any 13-bit address is passed through unmodified, including 13'h1FFF.
- req_valid deasserting after acceptance has no effect; the request is already latched.

Optional Feature:
- Macro: DMEM_BANK_GUARD_EN.
- When defined:
  - Bank 0 (addr[12:10]==0) is write-protected.
  - A store to bank 0 goes IDLE->ACCESS->IDLE with mem_read_write held 1, so no DMEM write occurs.
  - rsp_err pulses high for one cycle in ACCESS.
  - Loads from bank 0 behave normally.
- When undefined: rsp_err is tied 0 and all banks are writable.

Decomposition:
- Package dmem_ctrl_pkg:
  - ADDR_W, BANK_W=3, OFFS_W=10.
  - State enum {IDLE, ACCESS, WAIT, RESP}.
  - Constants MEM_RD=1'b1, MEM_WR=1'b0.
  - Protected-bank constant GUARD_BANK=3'd0.
- Sub-module dmem_lat_counter: 4-bit clear/enable counter with a terminal-count output (count == MEM_LAT-1). Instantiated once.

Test Plan:
- Reset: hold reset=0 for 5 cycles with req_valid=1 -> req_ready=1, busy=0, mem_read_write=1, mem_address=0, rsp_valid=0 throughout.
- Store: addr=13'h0405 (bank1, offs5), wdata=16'hBEEF, MEM_LAT=2 -> mem_read_write=0 for exactly 3 cycles with mem_address=13'h0405, mem_data_in=16'hBEEF; then busy=0 and no rsp_valid.
- Load-back: load addr=13'h0405 with DMEM model returning 16'hBEEF -> rsp_valid rises 4 cycles after handshake, rsp_rdata=16'hBEEF.
- Backpressure: load with rsp_ready=0 for 6 cycles -> rsp_valid and rsp_rdata stable, req_ready=0; rsp_ready=1 -> next cycle rsp_valid=0, req_ready=1.
- Bank sweep/wrap: loads at offset 10'h3FF for banks 0..7 (13'h03FF..13'h1FFF) -> each mem_address matches exactly, no wrap, 8 responses in order.
- Reset mid-op plus guard (DMEM_BANK_GUARD_EN):
  - Assert reset in WAIT of a store -> all outputs return to reset values immediately.
  - Then a store to 13'h0010 -> rsp_err=1 for one cycle, mem_read_write never 0.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dmem_ctrl_pkg
// Shared types and constants for the DMEM load/store sequencer.
//   ADDR_W / BANK_W / OFFS_W : address layout (bank in the top BANK_W bits)
//   state_e                  : sequencer state encoding
//   MEM_RD / MEM_WR          : DMEM read_write encoding
//   GUARD_BANK               : bank that is write-protected when
//                              DMEM_BANK_GUARD_EN is defined
// ---------------------------------------------------------------------------
package dmem_ctrl_pkg;

    localparam int ADDR_W = 13;
    localparam int BANK_W = 3;
    localparam int OFFS_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;

    localparam logic [BANK_W-1:0] GUARD_BANK = 3'd0;

    // Bank field of a full-width address.
    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: BANK_W];
    endfunction

endpackage

// File: rtl/dmem_lat_counter.sv
// ---------------------------------------------------------------------------
// dmem_lat_counter
// 4-bit clear/enable counter that measures the DMEM access latency.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear (has priority over en)
//   en    : increment enable
//   tc    : terminal count, high while count == MEM_LAT-1
// ---------------------------------------------------------------------------
module dmem_lat_counter #(
    parameter int MEM_LAT = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next-count selection: clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 4'd0;
        end else if (en) begin
            count_d = count_q + 4'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == 4'(MEM_LAT - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
// One-at-a-time load/store sequencer in front of DMEM_TopLevel.
// A request is latched on the req handshake, presented to DMEM for one ACCESS
// cycle plus MEM_LAT WAIT cycles, and (for loads) the captured read data is
// returned on the rsp channel until the core accepts it.
//
// Ports:
//   clock, reset              : clock, asynchronous active-low reset
//   req_valid/req_ready       : request handshake
//   req_we, req_addr, req_wdata : request (1 = store)
//   rsp_valid/rsp_ready       : load response handshake
//   rsp_rdata, rsp_err        : load data, error flag
//   busy                      : high whenever not IDLE
//   mem_address, mem_read_write, mem_data_in : to DMEM (read_write 1 = read)
//   mem_data_out              : from DMEM
//
// Optional build macro: DMEM_BANK_GUARD_EN
//   Makes bank 0 write-protected: a store there never writes DMEM, returns to
//   IDLE straight from ACCESS and pulses rsp_err for the ACCESS cycle.
//   Without the macro rsp_err is constant 0 and every bank is writable.
// ---------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 13,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read_write,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    import dmem_ctrl_pkg::*;

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_rw_q, mem_rw_d;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
    logic              is_store_q, is_store_d;
`ifdef DMEM_BANK_GUARD_EN
    logic              guard_q, guard_d;
`endif

    logic cnt_clr_s;
    logic cnt_en_s;
    logic cnt_tc_s;

    // The counter is cleared during ACCESS so it reads 0 on the first WAIT cycle.
    assign cnt_clr_s = (state_q == ACCESS);
    assign cnt_en_s  = (state_q == WAIT);

    dmem_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_counter (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .tc    (cnt_tc_s)
    );

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = 1'b0;
        busy_d        = busy_q;
        mem_address_d = mem_address_q;
        mem_rw_d      = mem_rw_q;
        mem_data_in_d = mem_data_in_q;
        is_store_d    = is_store_q;
`ifdef DMEM_BANK_GUARD_EN
        guard_d       = guard_q;
`endif
        case (state_q)
            IDLE: begin
                // DMEM stays in read mode while idle.
                mem_rw_d = MEM_RD;
                if (req_valid && req_ready_q) begin
                    state_d       = ACCESS;
                    req_ready_d   = 1'b0;
                    busy_d        = 1'b1;
                    mem_address_d = req_addr;
                    mem_data_in_d = req_wdata;
                    is_store_d    = req_we;
                    mem_rw_d      = req_we ? MEM_WR : MEM_RD;
`ifdef DMEM_BANK_GUARD_EN
                    if (req_we && (bank_of(req_addr) == GUARD_BANK)) begin
                        // Protected store: never drive a write, flag it in ACCESS.
                        mem_rw_d  = MEM_RD;
                        rsp_err_d = 1'b1;
                        guard_d   = 1'b1;
                    end else begin
                        guard_d   = 1'b0;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
`ifdef DMEM_BANK_GUARD_EN
                if (guard_q) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    guard_d     = 1'b0;
                end else begin
                    state_d = WAIT;
                end
`else
                state_d = WAIT;
`endif
            end
            WAIT: begin
                if (cnt_tc_s) begin
                    if (is_store_q) begin
                        // Write ends on the same edge the sequencer goes idle.
                        state_d     = IDLE;
                        mem_rw_d    = MEM_RD;
                        req_ready_d = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = mem_data_out;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
                mem_rw_d    = MEM_RD;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            mem_address_q <= '0;
            mem_rw_q      <= MEM_RD;
            mem_data_in_q <= '0;
            is_store_q    <= 1'b0;
`ifdef DMEM_BANK_GUARD_EN
            guard_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            busy_q        <= busy_d;
            mem_address_q <= mem_address_d;
            mem_rw_q      <= mem_rw_d;
            mem_data_in_q <= mem_data_in_d;
            is_store_q    <= is_store_d;
`ifdef DMEM_BANK_GUARD_EN
            guard_q       <= guard_d;
`endif
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;
    assign busy           = busy_q;
    assign mem_address    = mem_address_q;
    assign mem_read_write = mem_rw_q;
    assign mem_data_in    = mem_data_in_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Self-checking bench for dmem_access_ctrl (MEM_LAT = 2) with a behavioural
// DMEM model. Load expectations are pushed to a scoreboard queue when the
// request is issued and popped when the response beat is accepted.
// ---------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 13;
    localparam int MEM_LAT = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = 13'd0;
    logic [DATA_W-1:0] req_wdata = 16'd0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read_write;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    int errs   = 0;
    int checks = 0;
    logic [DATA_W-1:0] sb_q[$];

    dmem_access_ctrl #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .mem_address    (mem_address),
        .mem_read_write (mem_read_write),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out)
    );

    always #5 clock = ~clock;

    // DMEM model: unwritten words return a fixed address-derived pattern.
    bit [DATA_W-1:0] mem_arr [0:8191];
    bit              written [0:8191];

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return {3'b101, a} ^ 16'h1234;
    endfunction

    always @(posedge clock) begin
        if (mem_read_write == 1'b0) begin
            mem_arr[mem_address] <= mem_data_in;
            written[mem_address] <= 1'b1;
        end
    end

    assign mem_data_out = written[mem_address] ? mem_arr[mem_address] : pat(mem_address);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request and complete its handshake; returns just after the accept edge.
    task automatic issue(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errs++;
            $display("FAIL issue_ready: req_ready=%b required 1 within 20 cycles", req_ready);
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        req_addr  = $urandom_range(0, 8191);
        req_wdata = 16'($urandom);
    endtask

    // Issue a load, check latency, optional backpressure, then pop and compare.
    task automatic do_load(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp,
                           input int hold);
        int n;
        logic [DATA_W-1:0] held;
        logic [DATA_W-1:0] want;
        sb_q.push_back(exp);
        rsp_ready = 1'b0;
        issue(1'b0, addr, 16'h0000);
        checks++;
        if (mem_address !== addr || mem_read_write !== 1'b1) begin
            errs++;
            $display("FAIL load_addr: mem_address=%h rw=%b required %h rw=1", mem_address, mem_read_write, addr);
        end
        n = 1;
        while (rsp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != MEM_LAT + 2) begin
            errs++;
            $display("FAIL load_latency: rsp_valid after %0d cycles required %0d", n, MEM_LAT + 2);
        end
        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0 || busy !== 1'b1) begin
                errs++;
                $display("FAIL backpressure_hold: valid=%b rdata=%h ready=%b busy=%b required 1 %h 0 1",
                         rsp_valid, rsp_rdata, req_ready, busy, held);
            end
        end
        checks++;
        if (sb_q.size() == 0) begin
            errs++;
            $display("FAIL scoreboard_empty: no expected entry for rdata=%h", rsp_rdata);
        end else begin
            want = sb_q.pop_front();
            if (rsp_rdata !== want) begin
                errs++;
                $display("FAIL load_data: rsp_rdata=%h required %h (addr %h)", rsp_rdata, want, addr);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL rsp_release: valid=%b ready=%b busy=%b required 0 1 0", rsp_valid, req_ready, busy);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 13'h0123;
        req_wdata = 16'hAAAA;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (req_ready !== 1'b1 || busy !== 1'b0 || mem_read_write !== 1'b1 ||
                mem_address !== 13'd0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
                errs++;
                $display("FAIL reset_state: ready=%b busy=%b rw=%b addr=%h valid=%b err=%b required 1 0 1 0 0 0",
                         req_ready, busy, mem_read_write, mem_address, rsp_valid, rsp_err);
            end
        end
        req_valid = 1'b0;
        reset     = 1'b1;
        tick();
    endtask

    task automatic test_store(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                              input int exp_writes, input logic exp_err);
        int writes;
        logic saw_valid;
        logic saw_err;
        writes    = 0;
        saw_valid = 1'b0;
        saw_err   = 1'b0;
        issue(1'b1, addr, wd);
        for (int i = 0; i < 8; i++) begin
            if (mem_read_write === 1'b0) begin
                writes++;
                checks++;
                if (mem_address !== addr || mem_data_in !== wd) begin
                    errs++;
                    $display("FAIL store_bus: addr=%h data=%h required %h %h", mem_address, mem_data_in, addr, wd);
                end
            end
            if (rsp_valid === 1'b1) saw_valid = 1'b1;
            if (i == 0 && rsp_err === 1'b1) saw_err = 1'b1;
            if (i != 0 && rsp_err !== 1'b0) saw_err = 1'bx;
            tick();
        end
        checks++;
        if (writes != exp_writes) begin
            errs++;
            $display("FAIL store_write_cycles: %0d cycles required %0d", writes, exp_writes);
        end
        checks++;
        if (saw_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errs++;
            $display("FAIL store_done: rsp_valid_seen=%b busy=%b ready=%b required 0 0 1", saw_valid, busy, req_ready);
        end
        checks++;
        if (saw_err !== exp_err) begin
            errs++;
            $display("FAIL store_err: rsp_err pulse=%b required %b", saw_err, exp_err);
        end
    endtask

    task automatic test_load_back();
        rsp_ready = 1'b1;
        do_load(13'h0405, 16'hBEEF, 0);
    endtask

    task automatic test_backpressure();
        do_load(13'h0405, 16'hBEEF, 6);
    endtask

    task automatic test_bank_sweep();
        logic [ADDR_W-1:0] a;
        for (int b = 0; b < 8; b++) begin
            a = {3'(b), 10'h3FF};
            do_load(a, pat(a), 0);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errs++;
            $display("FAIL sweep_order: %0d responses outstanding required 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid_op();
        issue(1'b1, 13'h0800, 16'h1111);
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || mem_read_write !== 1'b1 || mem_address !== 13'd0 ||
            mem_data_in !== 16'd0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 16'd0) begin
            errs++;
            $display("FAIL mid_op_reset: ready=%b busy=%b rw=%b addr=%h din=%h valid=%b err=%b rdata=%h required reset values",
                     req_ready, busy, mem_read_write, mem_address, mem_data_in, rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_guard();
`ifdef DMEM_BANK_GUARD_EN
        test_store(13'h0010, 16'hDEAD, 0, 1'b1);
        do_load(13'h0010, pat(13'h0010), 0);
`else
        test_store(13'h0010, 16'hDEAD, MEM_LAT + 1, 1'b0);
        do_load(13'h0010, 16'hDEAD, 0);
`endif
    endtask

    initial begin
        test_reset();
        test_store(13'h0405, 16'hBEEF, MEM_LAT + 1, 1'b0);
        test_load_back();
        test_backpressure();
        test_bank_sweep();
        test_reset_mid_op();
        test_guard();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
